// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline control encodings, widths and hazard helper
package pipe_pkg;

    localparam int T_W      = 3;
    localparam int MD_CNT_W = 4;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    localparam logic [1:0] PC_SEL_SEQ     = 2'b00;
    localparam logic [1:0] PC_SEL_HANDLER = 2'b01;
    localparam logic [1:0] PC_SEL_EPC     = 2'b10;

    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    typedef enum logic {
        EXL_NORMAL  = 1'b0,
        EXL_HANDLER = 1'b1
    } exl_state_t;

    // A D-stage source collides with a producer whose result is not ready
    // by the time the consumer needs it; register 0 is never a real dependency.
    function automatic logic raw_hazard(
        input logic [4:0]     src,
        input logic [T_W-1:0] tuse,
        input logic [4:0]     dst,
        input logic [T_W-1:0] tnew
    );
        return (src != 5'd0) && (src == dst) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// rtl/md_busy_ctr.sv - mult/div busy counter with load, decrement and saturate
module md_busy_ctr
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                div,
    output logic                busy,
    output logic [MD_CNT_W-1:0] cnt
);

    localparam logic [MD_CNT_W-1:0] LOAD_MULT = MD_CNT_W'(MULT_CYC);
    localparam logic [MD_CNT_W-1:0] LOAD_DIV  = MD_CNT_W'(DIV_CYC);

    // Load on a start (a forced restart reloads), otherwise count down to zero and hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (go) begin
            cnt <= div ? LOAD_DIV : LOAD_MULT;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller with mult/div busy and exl state
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [4:0]     rs_D,
    input  logic [4:0]     rt_D,
    input  logic [T_W-1:0] Tuse_rs_D,
    input  logic [T_W-1:0] Tuse_rt_D,
    input  logic [4:0]     Dst_E,
    input  logic [4:0]     Dst_M,
    input  logic [T_W-1:0] Tnew_E,
    input  logic [T_W-1:0] Tnew_M,
    input  logic           md_start_E,
    input  logic           md_div_E,
    input  logic           md_use_D,
    input  logic           exc_M,
    input  logic           int_req,
    input  logic           eret_M,
    output logic           stall_F,
    output logic           stall_D,
    output logic           flush_FD,
    output logic           flush_DE,
    output logic           flush_EM,
    output logic [1:0]     pc_sel,
    output logic           exl,
    output logic           md_busy,
    output logic [31:0]    stall_cnt
);

    exl_state_t          state;
    logic                trap;
    logic                ret;
    logic                stall_hz;
    logic                stall_md;
    logic                stall;
    logic                md_go;
    logic                md_cnt_busy;
    logic [MD_CNT_W-1:0] md_cnt;

    assign exl  = (state == EXL_HANDLER);
    assign trap = exc_M | (int_req & ~exl);
    assign ret  = eret_M & ~trap;

    // A trapped starter never reaches the unit, so its load is dropped.
    assign md_go = md_start_E & ~trap;

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_ctr (
        .clk   (clk),
        .reset (reset),
        .go    (md_go),
        .div   (md_div_E),
        .busy  (md_cnt_busy),
        .cnt   (md_cnt)
    );

    assign md_busy  = md_cnt_busy | md_start_E;
    assign stall_md = md_use_D & md_busy;

    // Tuse/Tnew comparison of both D-stage sources against the E and M producers.
    always_comb begin
        stall_hz = raw_hazard(rs_D, Tuse_rs_D, Dst_E, Tnew_E)
                 | raw_hazard(rs_D, Tuse_rs_D, Dst_M, Tnew_M)
                 | raw_hazard(rt_D, Tuse_rt_D, Dst_E, Tnew_E)
                 | raw_hazard(rt_D, Tuse_rt_D, Dst_M, Tnew_M);
    end

    assign stall = stall_hz | stall_md;

    // Redirect and flush take priority over stalling: trap, then eret, then stall.
    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        flush_FD = 1'b0;
        flush_DE = 1'b0;
        flush_EM = 1'b0;
        pc_sel   = PC_SEL_SEQ;
        if (trap) begin
            flush_FD = 1'b1;
            flush_DE = 1'b1;
            flush_EM = 1'b1;
            pc_sel   = PC_SEL_HANDLER;
        end else if (ret) begin
            flush_FD = 1'b1;
            flush_DE = 1'b1;
            flush_EM = 1'b1;
            pc_sel   = PC_SEL_EPC;
        end else begin
            stall_F  = stall;
            stall_D  = stall;
            flush_DE = stall;
        end
    end

    // Exception-level FSM: any trap enters the handler, eret leaves it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EXL_NORMAL;
        end else begin
            case (state)
                EXL_NORMAL: begin
                    if (trap) state <= EXL_HANDLER;
                end
                EXL_HANDLER: begin
                    if (ret) state <= EXL_NORMAL;
                end
                default: state <= EXL_NORMAL;
            endcase
        end
    end

    // Running count of decode-stall cycles; wraps naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_D) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
